sccb_txn_seq: RTL and testbench
===============================

Name: sccb_txn_seq

Overview:
Transaction-level SCCB sequencer that sits between the camera register-init controller and the byte-level SCCB core (sccb_core). It accepts one register write or read request and expands it into the SCCB byte stream with start and stop framing. Frames are 3-phase for writes, or 2-phase write followed by 2-phase read for reads. Register-address width and data length are parametrised. Unlike the plain byte core, it detects NACKs and timeouts and returns a status.

Parameters:
REG_ADDR_BYTES, 2, register address length in bytes (1..2); sent MSB byte first.
DATA_BYTES, 1, data bytes per transaction (1..4); sent and received MSB byte first.
CHECK_NACK, 1, 1 = a NACK on any write-phase byte aborts the frame; 0 = the ack bit is ignored (SCCB "don't care" X bit).
TIMEOUT_CYCLES, 65535, maximum i_clk cycles spent in any core-wait state; width is $clog2(TIMEOUT_CYCLES+1).

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_req_valid  in  1  request valid
o_req_ready  out  1  high in IDLE only; request accepted when valid&&ready
i_req_rw  in  1  0 = write, 1 = read
i_dev_id  in  8  device write address (bit0 ignored, forced 0/1 internally)
i_reg_addr  in  8*REG_ADDR_BYTES  register address
i_wr_data  in  8*DATA_BYTES  write data
o_rsp_valid  out  1  one-cycle pulse at end of every accepted request
o_rsp_err  out  2  valid with o_rsp_valid: 00 ok, 01 NACK, 10 timeout
o_rd_data  out  8*DATA_BYTES  read data; valid with o_rsp_valid on an ok read
o_core_tx_data  out  8  byte to the core
o_core_tx_start  out  1  one-cycle pulse that begins a frame with o_core_tx_data
o_core_tx_stop  out  1  level request for a stop condition
i_core_tx_ready  in  1  core idle / bus free
i_core_ack  in  1  one-cycle pulse: the current tx byte's 9th bit has completed
i_core_nack  in  1  sampled ack bit (1 = NACK); qualified by i_core_ack
i_core_rx_ready  in  1  one-cycle pulse: i_core_rx_data holds a received byte
i_core_rx_data  in  8  received byte

Behaviour:
- Reset (async, any state): state=IDLE; every output 0 except o_req_ready=1; internal counters 0; o_rd_data=0.
- On accept, i_dev_id, i_reg_addr, i_wr_data and i_req_rw are latched. Later changes to the inputs have no effect until the next accept.
- States: IDLE, WAIT_BUS, START, SEND, STOP, RD_START, RD_RECV, RD_STOP, RESP.
- IDLE: on accept go to WAIT_BUS.
- WAIT_BUS: wait for i_core_tx_ready=1, then go to START.
- START:
  - o_core_tx_data = {dev_id[7:1],0}.
  - Pulse o_core_tx_start for exactly 1 cycle.
  - byte_idx=0; go to SEND.
- SEND:
  - Wait for i_core_ack.
  - If CHECK_NACK && i_core_nack: set err=01 and go to STOP.
  - Otherwise increment byte_idx. In the cycle after the ack, o_core_tx_data is updated to the next byte and held stable until the next ack.
  - Byte order:
    - write: id, addr MSB..LSB, data MSB..LSB; N = 1+REG_ADDR_BYTES+DATA_BYTES.
    - read phase 1: id, addr; N = 1+REG_ADDR_BYTES.
  - After the N-th ack, go to STOP.
- STOP:
  - Assert o_core_tx_stop until i_core_tx_ready rises, then deassert.
  - If a read is in progress, err=00 and phase 1 is done: go to RD_START.
  - Otherwise go to RESP.
- RD_START: wait for i_core_tx_ready, then pulse o_core_tx_start with {dev_id[7:1],1}. Wait for i_core_ack (NACK check as in SEND), then go to RD_RECV.
- RD_RECV:
  - On each i_core_rx_ready, shift i_core_rx_data into the LSB of the rd shift register (first byte ends in the MSB).
  - After the DATA_BYTES-th byte, go to RD_STOP.
- RD_STOP: same as STOP, then go to RESP.
- RESP:
  - Pulse o_rsp_valid with o_rsp_err. On err≠00, o_rd_data keeps its previous value.
  - Go to IDLE; o_req_ready returns the next cycle.
- Timeout:
  - The counter clears on every state change and on every i_core_ack / i_core_rx_ready. It counts in WAIT_BUS, SEND, RD_START, RD_RECV, STOP and RD_STOP.
  - Reaching TIMEOUT_CYCLES sets err=10 and goes to STOP.
  - A timeout inside STOP or RD_STOP drops o_core_tx_stop and goes to RESP.
- A NACK or timeout always produces exactly one o_rsp_valid and never starts read phase 2.
- i_core_ack, i_core_rx_ready and i_core_nack are ignored outside the wait states that use them.
- Minimum latency from accept to o_rsp_valid, with a core that answers instantly: WAIT_BUS 1 + START 1 + one cycle per byte + STOP 1 + RESP 1.

Test Plan:
- REG_ADDR_BYTES=2, DATA_BYTES=1. Write dev 0x78, addr 0xBEEF, data 0xAA, no NACK.
  -> tx_start with 0x78; bytes 0xBE, 0xEF, 0xAA; stop after the 4th ack.
  -> o_rsp_valid with err 00; o_req_ready low from accept until after RESP.
- Read dev 0x78, addr 0x3008; core returns 0x42.
  -> bytes 0x78, 0x30, 0x08, stop; then start with 0x79, then stop.
  -> o_rd_data=0x42, err 00.
- CHECK_NACK=1, NACK on the 2nd byte of a write.
  -> no further bytes; stop asserted; err 01.
  -> With CHECK_NACK=0 and the same stimulus, the full frame is sent and err 00.
- TIMEOUT_CYCLES=100, core never acks the 3rd byte.
  -> stop asserted 100 cycles after the 2nd ack; err 10 reported.
  -> A following request completes normally.
- Assert i_rst while in SEND (read phase 1).
  -> all outputs immediately at reset values, o_req_ready=1.
  -> A new write afterwards produces the correct full byte stream.
- REG_ADDR_BYTES=1, DATA_BYTES=2. Write addr 0x12, data 0xA55A -> bytes 0x78, 0x12, 0xA5, 0x5A.
  -> A read returning 0x11 then 0x22 gives o_rd_data=0x1122.

Source files
------------

// File: rtl/sccb_txn_seq.sv
// sccb_txn_seq: transaction-level SCCB sequencer.
// Expands one register write or read request into the SCCB byte stream with
// start/stop framing. Reports ok / NACK / timeout.
//
// Request handshake: a request transfers on a rising i_clk edge where
// i_req_valid && o_req_ready. o_req_ready is high only in IDLE. Exactly one
// o_rsp_valid pulse follows every accepted request.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_valid / o_req_ready    request handshake
//   i_req_rw                     0 = write, 1 = read
//   i_dev_id                     device write address (bit0 ignored)
//   i_reg_addr, i_wr_data        register address / write data, MSB byte first
//   o_rsp_valid, o_rsp_err       response pulse and status (00 ok, 01 NACK, 10 timeout)
//   o_rd_data                    read data, updated only by a successful read
//   o_core_tx_*                  byte, start pulse and stop level toward the core
//   i_core_*                     ready, ack/nack, receive strobe and byte from the core
//   o_dbg_state                  current FSM state encoding
module sccb_txn_seq #(
   parameter int REG_ADDR_BYTES = 2,
   parameter int DATA_BYTES     = 1,
   parameter bit CHECK_NACK     = 1'b1,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_rw,
   input  logic [7:0]                i_dev_id,
   input  logic [8*REG_ADDR_BYTES-1:0] i_reg_addr,
   input  logic [8*DATA_BYTES-1:0]   i_wr_data,
   output logic                      o_rsp_valid,
   output logic [1:0]                o_rsp_err,
   output logic [8*DATA_BYTES-1:0]   o_rd_data,
   output logic [7:0]                o_core_tx_data,
   output logic                      o_core_tx_start,
   output logic                      o_core_tx_stop,
   input  logic                      i_core_tx_ready,
   input  logic                      i_core_ack,
   input  logic                      i_core_nack,
   input  logic                      i_core_rx_ready,
   input  logic [7:0]                i_core_rx_data,
   output logic [3:0]                o_dbg_state
);

   localparam int AW    = 8*REG_ADDR_BYTES;
   localparam int DW    = 8*DATA_BYTES;
   localparam int N_WR  = 1 + REG_ADDR_BYTES + DATA_BYTES;
   localparam int N_RD1 = 1 + REG_ADDR_BYTES;
   localparam int FW    = 8*N_WR;
   localparam int IDX_W = $clog2(N_WR + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      IDLE, WAIT_BUS, START, SEND, STOP, RD_START, RD_RECV, RD_STOP, RESP
   } state_t;

   state_t             state_q, state_d;
   logic [6:0]         dev_hi_q;
   logic [AW-1:0]      reg_addr_q;
   logic [DW-1:0]      wr_data_q;
   logic               rw_q;
   logic [FW-1:0]      tx_sh_q;
   logic [IDX_W-1:0]   byte_idx_q;
   logic [1:0]         err_q, err_d;
   logic               rd_started_q;
   logic [TO_W-1:0]    to_cnt_q;
   logic [DW-1:0]      rd_sh_q;
   logic [DW-1:0]      rd_data_q;
   logic [IDX_W-1:0]   n_bytes;
   logic               counting;
   logic               to_exp;
   logic               unused_dev_lsb;

   assign unused_dev_lsb = i_dev_id[0];

   // Read phase 1 stops after the address; writes carry the data as well.
   assign n_bytes  = rw_q ? IDX_W'(N_RD1) : IDX_W'(N_WR);
   assign counting = state_q inside {WAIT_BUS, SEND, STOP, RD_START, RD_RECV, RD_STOP};
   // Fires on the last of TIMEOUT_CYCLES consecutive cycles without progress.
   assign to_exp   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (i_req_valid) begin
            state_d = WAIT_BUS;
            err_d   = 2'b00;
         end
         WAIT_BUS: begin
            if (i_core_tx_ready) state_d = START;
            else if (to_exp) begin err_d = 2'b10; state_d = STOP; end
         end
         START: state_d = SEND;
         SEND: begin
            if (i_core_ack) begin
               if (CHECK_NACK && i_core_nack) begin
                  err_d   = 2'b01;
                  state_d = STOP;
               end else if (byte_idx_q + IDX_W'(1) == n_bytes) begin
                  state_d = STOP;
               end
            end else if (to_exp) begin
               err_d   = 2'b10;
               state_d = STOP;
            end
         end
         STOP: begin
            if (i_core_tx_ready) state_d = (rw_q && err_q == 2'b00) ? RD_START : RESP;
            else if (to_exp) begin err_d = 2'b10; state_d = RESP; end
         end
         RD_START: begin
            if (rd_started_q && i_core_ack) begin
               if (CHECK_NACK && i_core_nack) begin
                  err_d   = 2'b01;
                  state_d = STOP;
               end else begin
                  state_d = RD_RECV;
               end
            end else if (to_exp) begin
               err_d   = 2'b10;
               state_d = STOP;
            end
         end
         RD_RECV: begin
            if (i_core_rx_ready) begin
               if (byte_idx_q == IDX_W'(DATA_BYTES - 1)) state_d = RD_STOP;
            end else if (to_exp) begin
               err_d   = 2'b10;
               state_d = STOP;
            end
         end
         RD_STOP: begin
            if (i_core_tx_ready) state_d = RESP;
            else if (to_exp) begin err_d = 2'b10; state_d = RESP; end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         dev_hi_q     <= '0;
         reg_addr_q   <= '0;
         wr_data_q    <= '0;
         rw_q         <= 1'b0;
         tx_sh_q      <= '0;
         byte_idx_q   <= '0;
         err_q        <= 2'b00;
         rd_started_q <= 1'b0;
         to_cnt_q     <= '0;
         rd_sh_q      <= '0;
         rd_data_q    <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;

         if (state_d != state_q || i_core_ack || i_core_rx_ready || !counting)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + TO_W'(1);

         case (state_q)
            IDLE: if (i_req_valid) begin
               dev_hi_q     <= i_dev_id[7:1];
               reg_addr_q   <= i_reg_addr;
               wr_data_q    <= i_wr_data;
               rw_q         <= i_req_rw;
               rd_started_q <= 1'b0;
            end
            START: begin
               tx_sh_q    <= {dev_hi_q, 1'b0, reg_addr_q, wr_data_q};
               byte_idx_q <= '0;
            end
            SEND: if (i_core_ack) begin
               tx_sh_q    <= tx_sh_q << 8;
               byte_idx_q <= byte_idx_q + IDX_W'(1);
            end
            STOP: rd_started_q <= 1'b0;
            RD_START: begin
               // The start pulse is taken by the core on the same edge.
               if (!rd_started_q && i_core_tx_ready) rd_started_q <= 1'b1;
               if (rd_started_q && i_core_ack) byte_idx_q <= '0;
            end
            RD_RECV: if (i_core_rx_ready) begin
               rd_sh_q    <= DW'({rd_sh_q, i_core_rx_data});
               byte_idx_q <= byte_idx_q + IDX_W'(1);
            end
            default: ;
         endcase

         // Publish read data on entry to RESP so it is valid with o_rsp_valid.
         if (state_q == RD_STOP && state_d == RESP && err_d == 2'b00)
            rd_data_q <= rd_sh_q;
      end
   end

   always_comb begin
      o_core_tx_data = 8'h00;
      case (state_q)
         START:    o_core_tx_data = {dev_hi_q, 1'b0};
         SEND:     o_core_tx_data = tx_sh_q[FW-1 -: 8];
         RD_START: o_core_tx_data = {dev_hi_q, 1'b1};
         default:  o_core_tx_data = 8'h00;
      endcase
   end

   assign o_core_tx_start = (state_q == START) ||
                            (state_q == RD_START && !rd_started_q && i_core_tx_ready);
   assign o_core_tx_stop  = (state_q == STOP) || (state_q == RD_STOP);
   assign o_req_ready     = (state_q == IDLE);
   assign o_rsp_valid     = (state_q == RESP);
   assign o_rsp_err       = (state_q == RESP) ? err_q : 2'b00;
   assign o_rd_data       = rd_data_q;
   assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_sccb_txn_seq.sv
// Directed bench for sccb_txn_seq. Three instances share the core-side
// stimulus; each has its own request valid so only one is active at a time.
//   dut_a: REG_ADDR_BYTES=2, DATA_BYTES=1, CHECK_NACK=1, TIMEOUT_CYCLES=100
//   dut_b: REG_ADDR_BYTES=2, DATA_BYTES=1, CHECK_NACK=0, TIMEOUT_CYCLES=100
//   dut_c: REG_ADDR_BYTES=1, DATA_BYTES=2, CHECK_NACK=1, TIMEOUT_CYCLES=100
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sccb_txn_seq;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus
   logic        rv_a = 0, rv_b = 0, rv_c = 0;
   logic        rw = 0;
   logic [7:0]  dev = 0;
   logic [15:0] addr = 0, wdata = 0;
   logic        tx_ready = 1, ack = 0, nack = 0, rx_rdy = 0;
   logic [7:0]  rx_data = 0;

   // per-instance outputs
   logic        rdy_a, rspv_a, txs_a, txp_a;
   logic [1:0]  err_a;
   logic [7:0]  rd_a, txd_a;
   logic [3:0]  st_a;
   logic        rdy_b, rspv_b, txs_b, txp_b;
   logic [1:0]  err_b;
   logic [7:0]  rd_b, txd_b;
   logic [3:0]  st_b;
   logic        rdy_c, rspv_c, txs_c, txp_c;
   logic [1:0]  err_c;
   logic [15:0] rd_c;
   logic [7:0]  txd_c;
   logic [3:0]  st_c;

   sccb_txn_seq #(.REG_ADDR_BYTES(2), .DATA_BYTES(1), .CHECK_NACK(1'b1), .TIMEOUT_CYCLES(100)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_req_valid(rv_a), .o_req_ready(rdy_a), .i_req_rw(rw),
      .i_dev_id(dev), .i_reg_addr(addr), .i_wr_data(wdata[7:0]), .o_rsp_valid(rspv_a),
      .o_rsp_err(err_a), .o_rd_data(rd_a), .o_core_tx_data(txd_a), .o_core_tx_start(txs_a),
      .o_core_tx_stop(txp_a), .i_core_tx_ready(tx_ready), .i_core_ack(ack), .i_core_nack(nack),
      .i_core_rx_ready(rx_rdy), .i_core_rx_data(rx_data), .o_dbg_state(st_a));

   sccb_txn_seq #(.REG_ADDR_BYTES(2), .DATA_BYTES(1), .CHECK_NACK(1'b0), .TIMEOUT_CYCLES(100)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_req_valid(rv_b), .o_req_ready(rdy_b), .i_req_rw(rw),
      .i_dev_id(dev), .i_reg_addr(addr), .i_wr_data(wdata[7:0]), .o_rsp_valid(rspv_b),
      .o_rsp_err(err_b), .o_rd_data(rd_b), .o_core_tx_data(txd_b), .o_core_tx_start(txs_b),
      .o_core_tx_stop(txp_b), .i_core_tx_ready(tx_ready), .i_core_ack(ack), .i_core_nack(nack),
      .i_core_rx_ready(rx_rdy), .i_core_rx_data(rx_data), .o_dbg_state(st_b));

   sccb_txn_seq #(.REG_ADDR_BYTES(1), .DATA_BYTES(2), .CHECK_NACK(1'b1), .TIMEOUT_CYCLES(100)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_req_valid(rv_c), .o_req_ready(rdy_c), .i_req_rw(rw),
      .i_dev_id(dev), .i_reg_addr(addr[7:0]), .i_wr_data(wdata), .o_rsp_valid(rspv_c),
      .o_rsp_err(err_c), .o_rd_data(rd_c), .o_core_tx_data(txd_c), .o_core_tx_start(txs_c),
      .o_core_tx_stop(txp_c), .i_core_tx_ready(tx_ready), .i_core_ack(ack), .i_core_nack(nack),
      .i_core_rx_ready(rx_rdy), .i_core_rx_data(rx_data), .o_dbg_state(st_c));

   // observed outputs of the selected instance
   int          sel = 0;
   logic        o_rdy, o_rspv, o_txs, o_txp;
   logic [1:0]  o_err;
   logic [15:0] o_rd;
   logic [7:0]  o_txd;
   logic [3:0]  o_st;

   always_comb begin
      case (sel)
         1: begin
            o_rdy = rdy_b; o_rspv = rspv_b; o_txs = txs_b; o_txp = txp_b;
            o_err = err_b; o_rd = {8'h00, rd_b}; o_txd = txd_b; o_st = st_b;
         end
         2: begin
            o_rdy = rdy_c; o_rspv = rspv_c; o_txs = txs_c; o_txp = txp_c;
            o_err = err_c; o_rd = rd_c; o_txd = txd_c; o_st = st_c;
         end
         default: begin
            o_rdy = rdy_a; o_rspv = rspv_a; o_txs = txs_a; o_txp = txp_a;
            o_err = err_a; o_rd = {8'h00, rd_a}; o_txd = txd_a; o_st = st_a;
         end
      endcase
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks: the bench plays the byte-level core
   task automatic req(input int s, input logic r, input logic [7:0] d,
                      input logic [15:0] a, input logic [15:0] w, input string tag);
      sel = s; rw = r; dev = d; addr = a; wdata = w;
      #1;
      chk(32'(o_rdy), 1, {tag, "_ready_idle"});
      case (s)
         1: rv_b = 1'b1;
         2: rv_c = 1'b1;
         default: rv_a = 1'b1;
      endcase
      @(negedge clk);
      rv_a = 0; rv_b = 0; rv_c = 0;
      chk(32'(o_rdy), 0, {tag, "_ready_busy"});
      // scramble request inputs: the accepted request must already be latched
      rw = ~r; dev = 8'h00; addr = 16'hFFFF; wdata = 16'h0000;
   endtask

   task automatic exp_start(input logic [7:0] exp, input string tag);
      int n = 0;
      while (o_txs !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk(32'(o_txs), 1, {tag, "_start"});
      chk(32'(o_txd), 32'(exp), {tag, "_start_byte"});
      @(negedge clk);
      chk(32'(o_txs), 0, {tag, "_start_pulse"});
      tx_ready = 1'b0;
   endtask

   task automatic ack_byte(input logic [7:0] exp, input logic nk, input string tag);
      chk(32'(o_txd), 32'(exp), {tag, "_byte"});
      ack = 1'b1; nack = nk;
      @(negedge clk);
      ack = 1'b0; nack = 1'b0;
      @(negedge clk);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data = b; rx_rdy = 1'b1;
      @(negedge clk);
      rx_rdy = 1'b0; rx_data = 8'h00;
      @(negedge clk);
   endtask

   task automatic exp_stop(input string tag);
      int n = 0;
      while (o_txp !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk(32'(o_txp), 1, {tag, "_stop"});
      chk(32'(o_txs), 0, {tag, "_no_start_in_stop"});
      @(negedge clk);
      chk(32'(o_txp), 1, {tag, "_stop_held"});
      tx_ready = 1'b1;
      @(negedge clk);
      chk(32'(o_txp), 0, {tag, "_stop_released"});
   endtask

   task automatic exp_rsp(input logic [1:0] e, input logic [15:0] rd, input string tag);
      int n = 0;
      while (o_rspv !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk(32'(o_rspv), 1, {tag, "_rsp_valid"});
      chk(32'(o_err), 32'(e), {tag, "_rsp_err"});
      chk(32'(o_rd), 32'(rd), {tag, "_rd_data"});
      chk(32'(o_rdy), 0, {tag, "_ready_in_resp"});
      @(negedge clk);
      chk(32'(o_rspv), 0, {tag, "_rsp_pulse"});
      chk(32'(o_rdy), 1, {tag, "_ready_back"});
   endtask

   task automatic write_frame(input int s, input logic [7:0] id, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input string tag);
      exp_start(id, tag);
      ack_byte(id, 1'b0, {tag, "_b0"});
      ack_byte(b1, 1'b0, {tag, "_b1"});
      ack_byte(b2, 1'b0, {tag, "_b2"});
      ack_byte(b3, 1'b0, {tag, "_b3"});
      exp_stop(tag);
   endtask

   initial begin
      int n;
      // reset state
      #3;
      chk(32'(o_rdy), 1, "rst_ready");
      chk(32'(o_rspv), 0, "rst_rsp_valid");
      chk(32'(o_err), 0, "rst_rsp_err");
      chk(32'(o_rd), 0, "rst_rd_data");
      chk(32'(o_txd), 0, "rst_tx_data");
      chk(32'(o_txs), 0, "rst_tx_start");
      chk(32'(o_txp), 0, "rst_tx_stop");
      chk(32'(o_st), 0, "rst_state");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // plain write 0x78 / 0xBEEF / 0xAA
      req(0, 1'b0, 8'h78, 16'hBEEF, 16'h00AA, "wr1");
      write_frame(0, 8'h78, 8'hBE, 8'hEF, 8'hAA, "wr1");
      exp_rsp(2'b00, 16'h0000, "wr1");

      // read 0x78 / 0x3008 returning 0x42
      req(0, 1'b1, 8'h78, 16'h3008, 16'h0000, "rd1");
      exp_start(8'h78, "rd1");
      ack_byte(8'h78, 1'b0, "rd1_b0");
      ack_byte(8'h30, 1'b0, "rd1_b1");
      ack_byte(8'h08, 1'b0, "rd1_b2");
      exp_stop("rd1_p1");
      exp_start(8'h79, "rd1_p2");
      ack_byte(8'h79, 1'b0, "rd1_p2_id");
      rx_byte(8'h42);
      exp_stop("rd1_p2");
      exp_rsp(2'b00, 16'h0042, "rd1");

      // NACK on the 2nd byte aborts; read data from before is retained
      req(0, 1'b0, 8'h78, 16'hBEEF, 16'h00AA, "nack");
      exp_start(8'h78, "nack");
      ack_byte(8'h78, 1'b0, "nack_b0");
      ack_byte(8'hBE, 1'b1, "nack_b1");
      chk(32'(o_txp), 1, "nack_stop_now");
      chk(32'(o_txd), 0, "nack_no_more_bytes");
      exp_stop("nack");
      exp_rsp(2'b01, 16'h0042, "nack");

      // same stimulus with NACK checking disabled: full frame, ok
      req(1, 1'b0, 8'h78, 16'hBEEF, 16'h00AA, "nonack");
      exp_start(8'h78, "nonack");
      ack_byte(8'h78, 1'b0, "nonack_b0");
      ack_byte(8'hBE, 1'b1, "nonack_b1");
      ack_byte(8'hEF, 1'b0, "nonack_b2");
      ack_byte(8'hAA, 1'b0, "nonack_b3");
      exp_stop("nonack");
      exp_rsp(2'b00, 16'h0000, "nonack");

      // 3rd byte never acked: stop 100 cycles after the 2nd ack edge
      req(0, 1'b0, 8'h78, 16'hBEEF, 16'h00AA, "tmo");
      exp_start(8'h78, "tmo");
      ack_byte(8'h78, 1'b0, "tmo_b0");
      ack_byte(8'hBE, 1'b0, "tmo_b1");
      n = 1;
      while (o_txp !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      chk(32'(n), 100, "tmo_stop_delay");
      exp_stop("tmo");
      exp_rsp(2'b10, 16'h0042, "tmo");

      // normal request afterwards; dev_id bit0 is forced to 0
      req(0, 1'b0, 8'h21, 16'h0102, 16'h005C, "wr2");
      write_frame(0, 8'h20, 8'h01, 8'h02, 8'h5C, "wr2");
      exp_rsp(2'b00, 16'h0042, "wr2");

      // reset in the middle of read phase 1
      req(0, 1'b1, 8'h78, 16'h3008, 16'h0000, "rstmid");
      exp_start(8'h78, "rstmid");
      ack_byte(8'h78, 1'b0, "rstmid_b0");
      rst = 1'b1;
      #1;
      chk(32'(o_rdy), 1, "rstmid_ready");
      chk(32'(o_txd), 0, "rstmid_tx_data");
      chk(32'(o_txs), 0, "rstmid_tx_start");
      chk(32'(o_txp), 0, "rstmid_tx_stop");
      chk(32'(o_rspv), 0, "rstmid_rsp_valid");
      chk(32'(o_rd), 0, "rstmid_rd_data");
      chk(32'(o_st), 0, "rstmid_state");
      @(negedge clk);
      rst = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      req(0, 1'b0, 8'h78, 16'hBEEF, 16'h00AA, "wr3");
      write_frame(0, 8'h78, 8'hBE, 8'hEF, 8'hAA, "wr3");
      exp_rsp(2'b00, 16'h0000, "wr3");

      // 1-byte address, 2-byte data instance
      req(2, 1'b0, 8'h78, 16'h0012, 16'hA55A, "c_wr");
      write_frame(2, 8'h78, 8'h12, 8'hA5, 8'h5A, "c_wr");
      exp_rsp(2'b00, 16'h0000, "c_wr");

      req(2, 1'b1, 8'h78, 16'h0030, 16'h0000, "c_rd");
      exp_start(8'h78, "c_rd");
      ack_byte(8'h78, 1'b0, "c_rd_b0");
      ack_byte(8'h30, 1'b0, "c_rd_b1");
      exp_stop("c_rd_p1");
      exp_start(8'h79, "c_rd_p2");
      ack_byte(8'h79, 1'b0, "c_rd_p2_id");
      rx_byte(8'h11);
      rx_byte(8'h22);
      exp_stop("c_rd_p2");
      exp_rsp(2'b00, 16'h1122, "c_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
